// File: rtl/axi4s_if.sv
// AXI4-Stream video bus: pixel data, start-of-frame on tuser, end-of-line on tlast.
interface axi4s_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// Video test-pattern source: streams H_ACTIVE x V_ACTIVE RGB565 frames over AXI4-Stream
// with fully registered outputs; pattern and colour are latched once per frame.
module axis_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic        axi_clk_i,
    input  logic        axi_rst_ni,
    input  logic        enable_i,
    input  logic [1:0]  pattern_i,
    input  logic [15:0] color_i,
    axi4s_if.master     m_axis,
    output logic        frame_done_o,
    output logic        busy_o
);
    localparam int unsigned XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned BarW = H_ACTIVE / 8;
    localparam logic [XW-1:0] XMax = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] YMax = YW'(V_ACTIVE - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [1:0]            pat_q, pat_d;
    logic [15:0]           col_q, col_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  user_q, user_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;
    logic                  load;

    function automatic logic [15:0] pixel(input logic [XW-1:0] px, input logic [YW-1:0] py,
                                          input logic [1:0] pat, input logic [15:0] col);
        logic [2:0]  bar;
        logic [5:0]  g6;
        logic [15:0] res;
        bar = 3'(32'(px) / BarW);
        g6  = 6'(8'(px) >> 2);
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    res = 16'hFFFF;
                    3'd1:    res = 16'hFFE0;
                    3'd2:    res = 16'h07FF;
                    3'd3:    res = 16'h07E0;
                    3'd4:    res = 16'hF81F;
                    3'd5:    res = 16'hF800;
                    3'd6:    res = 16'h001F;
                    default: res = 16'h0000;
                endcase
            end
            2'd1:    res = {g6[5:1], g6, g6[5:1]};
            2'd2:    res = (((32'(px) ^ 32'(py)) & 32'h20) != 0) ? 16'hFFFF : 16'h0000;
            default: res = col;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pat_d   = pat_q;
        col_d   = col_q;
        valid_d = valid_q;
        data_d  = data_q;
        user_d  = user_q;
        last_d  = last_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StRun;
                    x_d     = '0;
                    y_d     = '0;
                    pat_d   = pattern_i;
                    col_d   = color_i;
                    load    = 1'b1;
                end
            end
            StRun: begin
                // In RUN the output beat is always valid, so tready alone marks a transfer.
                if (m_axis.tready) begin
                    load = 1'b1;
                    if (x_q == XMax) begin
                        x_d = '0;
                        if (y_q == YMax) begin
                            y_d    = '0;
                            done_d = 1'b1;
                            if (enable_i) begin
                                pat_d = pattern_i;
                                col_d = color_i;
                            end else begin
                                state_d = StIdle;
                                load    = 1'b0;
                                valid_d = 1'b0;
                                data_d  = '0;
                                user_d  = 1'b0;
                                last_d  = 1'b0;
                            end
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) begin
            valid_d = 1'b1;
            data_d  = DATA_WIDTH'(pixel(x_d, y_d, pat_d, col_d));
            user_d  = (x_d == '0) && (y_d == '0);
            last_d  = (x_d == XMax);
        end
    end

    always_ff @(posedge axi_clk_i or negedge axi_rst_ni) begin
        if (!axi_rst_ni) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tuser  = user_q;
    assign m_axis.tlast  = last_q;
    assign frame_done_o  = done_q;
    assign busy_o        = (state_q == StRun);
endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: a 16x4 instance for most cases, a 64x2 one for checkerboard.
module tb_axis_pattern_gen;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int H2 = 64;
    localparam int V2 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        en2 = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [15:0] col = 16'h0;
    logic        tready = 1'b1;
    bit          rand_ready = 1'b0;
    logic        done1, busy1, done2, busy2;

    axi4s_if #(.DATA_WIDTH(16)) bus1 ();
    axi4s_if #(.DATA_WIDTH(16)) bus2 ();
    assign bus1.tready = tready;
    assign bus2.tready = 1'b1;

    axis_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_WIDTH(16)) dut1 (
        .axi_clk_i   (clk),
        .axi_rst_ni  (rst_n),
        .enable_i    (en),
        .pattern_i   (pat),
        .color_i     (col),
        .m_axis      (bus1),
        .frame_done_o(done1),
        .busy_o      (busy1)
    );

    axis_pattern_gen #(.H_ACTIVE(H2), .V_ACTIVE(V2), .DATA_WIDTH(16)) dut2 (
        .axi_clk_i   (clk),
        .axi_rst_ni  (rst_n),
        .enable_i    (en2),
        .pattern_i   (2'd2),
        .color_i     (16'h0000),
        .m_axis      (bus2),
        .frame_done_o(done2),
        .busy_o      (busy2)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] data; logic user; logic last; int cyc;} beat_t;
    typedef struct {int beat; logic [15:0] data; logic user; logic last;} vec_t;

    beat_t q1[$];
    beat_t q2[$];
    beat_t chk_q[$];
    vec_t  vecs[12];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    done_cnt1 = 0;
    int    done_cnt2 = 0;
    int    cyc = 0;
    logic        hold_v = 1'b0;
    logic [17:0] hold_p = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int x, input int y, input int hact,
                                              input logic [1:0] p, input logic [15:0] c);
        logic [7:0] g;
        case (p)
            2'd0: begin
                case (x / (hact / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1: begin
                g = 8'(x % 256);
                return {g[7:3], g[7:2], g[7:3]};
            end
            2'd2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
            default: return c;
        endcase
    endfunction

    task automatic check_frame(input int base, input int hact, input int vact,
                               input logic [1:0] p, input logic [15:0] c, input string tag);
        logic [31:0] act, exp;
        for (int i = 0; i < hact * vact; i++) begin
            exp = {14'd0, model_pix(i % hact, i / hact, hact, p, c), (i == 0), ((i % hact) == hact - 1)};
            if (base + i < chk_q.size())
                act = {14'd0, chk_q[base+i].data, chk_q[base+i].user, chk_q[base+i].last};
            else
                act = 32'hFFFF_FFFF;
            cmp($sformatf("%s[%0d]", tag, i), act, exp);
        end
    endtask

    task automatic wait_beats(input int which, input int n, input int budget, input string tag);
        int k = 0;
        while (((which == 1) ? q1.size() : q2.size()) < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (((which == 1) ? q1.size() : q2.size()) < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: beats %0d required %0d", tag,
                     (which == 1) ? q1.size() : q2.size(), n);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                cmp("hold_stable", {14'd0, bus1.tvalid, bus1.tdata, bus1.tuser, bus1.tlast},
                    {14'd0, 1'b1, hold_p});
            if (bus1.tvalid && bus1.tready)
                q1.push_back('{bus1.tdata, bus1.tuser, bus1.tlast, cyc});
            hold_v = bus1.tvalid && !bus1.tready;
            hold_p = {bus1.tdata, bus1.tuser, bus1.tlast};
            if (done1) done_cnt1++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus2.tvalid && bus2.tready)
                q2.push_back('{bus2.tdata, bus2.tuser, bus2.tlast, cyc});
            if (done2) done_cnt2++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,  16'hFFFF, 1'b1, 1'b0};
        vecs[1]  = '{1,  16'hFFFF, 1'b0, 1'b0};
        vecs[2]  = '{2,  16'hFFE0, 1'b0, 1'b0};
        vecs[3]  = '{3,  16'hFFE0, 1'b0, 1'b0};
        vecs[4]  = '{4,  16'h07FF, 1'b0, 1'b0};
        vecs[5]  = '{14, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{15, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{16, 16'hFFFF, 1'b0, 1'b0};
        vecs[8]  = '{26, 16'hF800, 1'b0, 1'b0};
        vecs[9]  = '{31, 16'h0000, 1'b0, 1'b1};
        vecs[10] = '{47, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{63, 16'h0000, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_tvalid", bus1.tvalid, 0);
        cmp("rst_tuser", bus1.tuser, 0);
        cmp("rst_tlast", bus1.tlast, 0);
        cmp("rst_tdata", bus1.tdata, 0);
        cmp("rst_frame_done", done1, 0);
        cmp("rst_busy", busy1, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Colour bars, single frame
        q1.delete();
        done_cnt1 = 0;
        pat = 2'd0;
        en = 1'b1;
        @(posedge clk);
        #1;
        cmp("first_tvalid", bus1.tvalid, 1);
        cmp("first_tuser", bus1.tuser, 1);
        cmp("first_tdata", bus1.tdata, 16'hFFFF);
        cmp("first_busy", busy1, 1);
        en = 1'b0;
        wait_beats(1, 64, 200, "bars");
        repeat (3) @(posedge clk);
        #1;
        cmp("bars_count", q1.size(), 64);
        cmp("bars_done_cnt", done_cnt1, 1);
        cmp("bars_idle_tvalid", bus1.tvalid, 0);
        cmp("bars_idle_busy", busy1, 0);
        cmp("bars_no_bubble", q1[63].cyc - q1[0].cyc, 63);
        foreach (vecs[i]) begin
            if (vecs[i].beat < q1.size())
                cmp($sformatf("bars_vec_beat%0d", vecs[i].beat),
                    {14'd0, q1[vecs[i].beat].data, q1[vecs[i].beat].user, q1[vecs[i].beat].last},
                    {14'd0, vecs[i].data, vecs[i].user, vecs[i].last});
            else
                cmp($sformatf("bars_vec_beat%0d", vecs[i].beat), 32'hFFFF_FFFF,
                    {14'd0, vecs[i].data, vecs[i].user, vecs[i].last});
        end
        chk_q = q1;
        check_frame(0, H, V, 2'd0, 16'h0, "bars_px");

        // Backpressure
        q1.delete();
        done_cnt1 = 0;
        rand_ready = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_beats(1, 64, 2000, "bp");
        rand_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cmp("bp_count", q1.size(), 64);
        cmp("bp_done_cnt", done_cnt1, 1);
        chk_q = q1;
        check_frame(0, H, V, 2'd0, 16'h0, "bp_px");

        // Pattern change mid-frame, back-to-back frames
        q1.delete();
        done_cnt1 = 0;
        en = 1'b1;
        wait_beats(1, 10, 100, "chg_a");
        pat = 2'd3;
        col = 16'h1234;
        wait_beats(1, 70, 200, "chg_b");
        en = 1'b0;
        wait_beats(1, 128, 200, "chg_c");
        repeat (4) @(posedge clk);
        #1;
        cmp("chg_count", q1.size(), 128);
        cmp("chg_done_cnt", done_cnt1, 2);
        cmp("chg_no_bubble", q1[127].cyc - q1[0].cyc, 127);
        chk_q = q1;
        check_frame(0, H, V, 2'd0, 16'h0, "chg_f0");
        check_frame(64, H, V, 2'd3, 16'h1234, "chg_f1");

        // Grey ramp
        q1.delete();
        pat = 2'd1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_beats(1, 64, 200, "grey");
        repeat (3) @(posedge clk);
        #1;
        chk_q = q1;
        check_frame(0, H, V, 2'd1, 16'h0, "grey_px");

        // Stop at beat 20
        q1.delete();
        done_cnt1 = 0;
        pat = 2'd0;
        en = 1'b1;
        wait_beats(1, 21, 100, "stop_a");
        en = 1'b0;
        wait_beats(1, 64, 200, "stop_b");
        repeat (5) @(posedge clk);
        #1;
        cmp("stop_count", q1.size(), 64);
        cmp("stop_done_cnt", done_cnt1, 1);
        cmp("stop_tvalid", bus1.tvalid, 0);
        cmp("stop_busy", busy1, 0);
        chk_q = q1;
        check_frame(0, H, V, 2'd0, 16'h0, "stop_px");

        // Reset mid-frame
        q1.delete();
        en = 1'b1;
        wait_beats(1, 30, 100, "rst_a");
        rst_n = 1'b0;
        #1;
        cmp("midrst_tvalid", bus1.tvalid, 0);
        cmp("midrst_tuser", bus1.tuser, 0);
        cmp("midrst_busy", busy1, 0);
        repeat (2) @(posedge clk);
        #1;
        q1.delete();
        done_cnt1 = 0;
        rst_n = 1'b1;
        wait_beats(1, 1, 20, "rst_b");
        en = 1'b0;
        cmp("rst_restart_head", {15'd0, q1[0].data, q1[0].user}, {15'd0, 16'hFFFF, 1'b1});
        wait_beats(1, 64, 200, "rst_c");
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_restart_count", q1.size(), 64);
        chk_q = q1;
        check_frame(0, H, V, 2'd0, 16'h0, "rst_px");

        // Checkerboard on the 64-wide instance
        q2.delete();
        done_cnt2 = 0;
        en2 = 1'b1;
        @(posedge clk);
        #1;
        en2 = 1'b0;
        wait_beats(2, 128, 400, "chk");
        repeat (3) @(posedge clk);
        #1;
        for (int p = 0; p < 64; p++)
            cmp($sformatf("chk_line0_px%0d", p), q2[p].data, (p < 32) ? 16'h0000 : 16'hFFFF);
        cmp("chk_done_cnt", done_cnt2, 1);
        cmp("chk_busy", busy2, 0);
        chk_q = q2;
        check_frame(0, H2, V2, 2'd2, 16'h0, "chk_px");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
